// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: defaults, FSM encoding
// and a lowest-set-index priority encoder.
package intr_pkg;

    localparam int N_IRQ_DEF      = 4;
    localparam int PC_W_DEF       = 10;
    localparam int VEC_BASE_DEF   = 'h3C0;
    localparam int VEC_STRIDE_DEF = 4;

    // Width of the encoder's index field; covers up to 32 lines.
    localparam int PRIO_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [PRIO_W-1:0] idx;
    } prio_t;

    // Lowest set bit wins; index 0 is the highest priority.
    function automatic prio_t lowest_set(input logic [31:0] vec);
        prio_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = PRIO_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// Per-line two-flop synchroniser followed by a delay flop; produces a
// one-cycle rise pulse for each low-to-high transition of an async input.
module intr_sync_edge #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sig_in,
    output logic [N-1:0] rise
);

    logic [N-1:0] s1;
    logic [N-1:0] s2;
    logic [N-1:0] s3;

    // Synchroniser chain s1 -> s2 plus the s3 delay used for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbour, forming a real chain.
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/intr_ctrl.sv
// Prioritised, nestable interrupt controller. Latches edges, applies mask
// and global enable, and presents one frozen vector at a time to the CPU.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int N_IRQ      = N_IRQ_DEF,
    parameter int PC_W       = PC_W_DEF,
    parameter int VEC_BASE   = VEC_BASE_DEF,
    parameter int VEC_STRIDE = VEC_STRIDE_DEF,
    localparam int ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             gie_we,
    input  logic             gie_wdata,
    input  logic             cpu_ack,
    input  logic             cpu_reti,
    output logic             irq_req,
    output logic [PC_W-1:0]  irq_vec,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service
);

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] mask_q;
    logic             gie_q;
    state_t           state_q;
    state_t           state_d;
    logic             load_req;
    logic             ack_fire;
    prio_t            best;
    prio_t            cur;
    logic             eligible;
    logic [N_IRQ-1:0] ack_bit;
    logic [N_IRQ-1:0] reti_bit;
    logic [PC_W-1:0]  vec_calc;

    intr_sync_edge #(.N(N_IRQ)) u_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_in (irq_in),
        .rise   (rise)
    );

    // Highest-priority enabled pending line versus the running handler level;
    // an empty in_service ranks below every line.
    assign best     = lowest_set(32'(pending & mask_q));
    assign cur      = lowest_set(32'(in_service));
    assign eligible = gie_q && best.valid && (!cur.valid || (best.idx < cur.idx));

    // Vector arithmetic is done in PC_W bits and wraps on overflow.
    assign vec_calc = PC_W'(VEC_BASE) + (PC_W'(best.idx) * PC_W'(VEC_STRIDE));

    // Next-state logic: latch a request from IDLE, hold it frozen in REQ
    // until the CPU acknowledges.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_d  = state_q;
        load_req = 1'b0;
        ack_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (eligible) begin
                    load_req = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (cpu_ack) begin
                    ack_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign irq_req = (state_q == REQ);

    // An ack outside REQ is ignored; reti retires the innermost (lowest
    // index) active handler, judged on the pre-edge in_service.
    assign ack_bit  = ack_fire ? (N_IRQ'(1) << irq_id) : '0;
    assign reti_bit = (cpu_reti && cur.valid) ? (N_IRQ'(1) << cur.idx) : '0;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Software-visible mask and global enable; only the CPU changes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            gie_q  <= 1'b0;
        end else begin
            if (mask_we) mask_q <= mask_wdata;
            if (gie_we)  gie_q  <= gie_wdata;
        end
    end

    // Pending edges: a new rise beats a same-cycle ack on that bit.
    // In-service: reti clear first, then ack set, so a shared bit ends up 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            in_service <= '0;
        end else begin
            pending    <= (pending & ~ack_bit) | rise;
            in_service <= (in_service & ~reti_bit) | ack_bit;
        end
    end

    // Request identity and vector are captured once and held through REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_id  <= '0;
            irq_vec <= '0;
        end else if (load_req) begin
            irq_id  <= best.idx[ID_W-1:0];
            irq_vec <= vec_calc;
        end
    end

endmodule
